// File: rtl/hc194_burst.sv
// WIDTH-bit universal shift register (hold / right / left / load) with a selectable fill source
// and a burst engine that performs CNT shifts from a single START pulse.
module hc194_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             S0,
  input  logic             S1,
  input  logic [WIDTH-1:0] D,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [1:0]       FILL,
  input  logic             START,
  input  logic [CNT_W-1:0] CNT,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   q_q;
  logic [CNT_W-1:0]   rem_q;
  logic               dir_left_q;
  logic [1:0]         fill_q;
  logic               busy_q;
  logic               done_q;

  logic [1:0]         fill_sel;
  logic               fill_r;
  logic               fill_l;
  logic [WIDTH-1:0]   q_shr;
  logic [WIDTH-1:0]   q_shl;
  logic [1:0]         mode;

  assign mode = {S1, S0};

  // During a burst the fill source is the one latched at START; serial inputs stay live.
  always_comb begin
    fill_sel = (state_q == StShift) ? fill_q : FILL;
    fill_r   = 1'b0;
    fill_l   = 1'b0;
    unique case (fill_sel)
      2'b00: begin
        fill_r = DSR;
        fill_l = DSL;
      end
      2'b01: begin
        fill_r = q_q[0];
        fill_l = q_q[WIDTH-1];
      end
      2'b10: begin
        fill_r = q_q[WIDTH-1];
        fill_l = q_q[0];
      end
      default: begin
        fill_r = 1'b0;
        fill_l = 1'b0;
      end
    endcase
    q_shr = {fill_r, q_q[WIDTH-1:1]};
    q_shl = {q_q[WIDTH-2:0], fill_l};
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_q    <= StIdle;
      q_q        <= '0;
      rem_q      <= '0;
      dir_left_q <= 1'b0;
      fill_q     <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (START && (mode == 2'b01 || mode == 2'b10)) begin
            dir_left_q <= S1;
            fill_q     <= FILL;
            rem_q      <= CNT;
            if (CNT != '0) begin
              state_q <= StShift;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end else begin
            unique case (mode)
              2'b01:   q_q <= q_shr;
              2'b10:   q_q <= q_shl;
              2'b11:   q_q <= D;
              default: q_q <= q_q;
            endcase
          end
        end
        StShift: begin
          q_q    <= dir_left_q ? q_shl : q_shr;
          rem_q  <= rem_q - 1'b1;
          done_q <= 1'b0;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign SO_R = q_q[0];
  assign SO_L = q_q[WIDTH-1];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_hc194_burst.sv
// Scoreboard bench for hc194_burst: a driver pushes per-edge expectations from a behavioural
// model, a negedge monitor pops and compares them against Q, SO_R, SO_L, BUSY and DONE.
module tb_hc194_burst;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          cp = 1'b0;
  logic          mr, s0, s1, dsr, dsl, start;
  logic [W-1:0]  d;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q;
  logic          so_r, so_l, busy, done;

  hc194_burst #(.WIDTH(W), .CNT_W(CW)) dut (
    .CP(cp), .MR(mr), .S0(s0), .S1(s1), .D(d), .DSR(dsr), .DSL(dsl), .FILL(fill),
    .START(start), .CNT(cnt), .Q(q), .SO_R(so_r), .SO_L(so_l), .BUSY(busy), .DONE(done)
  );

  always #5 cp = ~cp;

  typedef struct packed {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pending shift count plus latched burst settings.
  logic [W-1:0] m_q;
  int           m_rem;
  logic         m_left;
  logic [1:0]   m_fill;
  logic         m_done;

  function automatic logic fill_bit(input logic [W-1:0] v, input logic [1:0] f,
                                    input logic ser, input logic left);
    case (f)
      2'd0:    return ser;
      2'd1:    return left ? v[W-1] : v[0];
      2'd2:    return left ? v[0] : v[W-1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] do_shift(input logic [W-1:0] v, input logic left,
                                            input logic [1:0] f, input logic r_ser,
                                            input logic l_ser);
    logic b;
    b = fill_bit(v, f, left ? l_ser : r_ser, left);
    if (left) return (v << 1) | W'(b);
    else      return (v >> 1) | (W'(b) << (W - 1));
  endfunction

  task automatic step(input logic i_mr, input logic [1:0] i_s, input logic [W-1:0] i_d,
                      input logic i_dsr, input logic i_dsl, input logic [1:0] i_fill,
                      input logic i_start, input logic [CW-1:0] i_cnt);
    exp_t e;
    @(negedge cp);
    #1;
    mr = i_mr; s1 = i_s[1]; s0 = i_s[0]; d = i_d; dsr = i_dsr; dsl = i_dsl;
    fill = i_fill; start = i_start; cnt = i_cnt;
    if (i_mr) begin
      m_q = '0; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_q = do_shift(m_q, m_left, m_fill, i_dsr, i_dsl);
      m_rem--;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (i_start && (i_s == 2'b01 || i_s == 2'b10)) begin
        m_left = (i_s == 2'b10);
        m_fill = i_fill;
        m_rem  = int'(i_cnt);
        m_done = (i_cnt == 0);
      end else if (i_s == 2'b01) begin
        m_q = do_shift(m_q, 1'b0, i_fill, i_dsr, i_dsl);
      end else if (i_s == 2'b10) begin
        m_q = do_shift(m_q, 1'b1, i_fill, i_dsr, i_dsl);
      end else if (i_s == 2'b11) begin
        m_q = i_d;
      end
    end
    e.q = m_q; e.busy = (m_rem > 0); e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, '0);
  endtask

  // Monitor: every edge has exactly one expectation, consumed on the following falling edge.
  always @(negedge cp) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total += 4;
      if (q !== e.q) begin
        bad++; $display("FAIL q: got %h want %h at %0t", q, e.q, $time);
      end
      if (busy !== e.busy) begin
        bad++; $display("FAIL busy: got %b want %b at %0t", busy, e.busy, $time);
      end
      if (done !== e.done) begin
        bad++; $display("FAIL done: got %b want %b at %0t", done, e.done, $time);
      end
      if (so_r !== e.q[0] || so_l !== e.q[W-1]) begin
        bad++; $display("FAIL serial_out: got %b%b want %b%b at %0t", so_l, so_r, e.q[W-1],
                        e.q[0], $time);
      end
    end
  end

  initial begin
    mr = 1'b1; s0 = 0; s1 = 0; d = '0; dsr = 0; dsl = 0; fill = 0; start = 0; cnt = '0;
    m_q = '0; m_rem = 0; m_left = 0; m_fill = 0; m_done = 0;
    step(1'b1, 2'b00, 8'h00, 0, 0, 2'b00, 0, '0);
    // Reset from Q=FF with a burst running
    step(1'b0, 2'b11, 8'hFF, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b01, 8'h00, 0, 0, 2'b01, 1'b1, 4'd4);
    step(1'b0, 2'b00, 8'h00, 0, 0, 2'b00, 0, '0);
    step(1'b1, 2'b00, 8'h00, 0, 0, 2'b00, 0, '0);
    // Load and hold
    step(1'b0, 2'b11, 8'hA5, 0, 0, 2'b00, 0, '0);
    idle(3);
    // Direct shifts
    step(1'b0, 2'b01, 8'h00, 1'b1, 0, 2'b00, 0, '0);
    step(1'b0, 2'b11, 8'hA5, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b10, 8'h00, 0, 1'b0, 2'b00, 0, '0);
    // Rotate-right burst of 3 from 81, with D/S toggling meanwhile
    step(1'b0, 2'b11, 8'h81, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b01, 8'h00, 0, 0, 2'b01, 1'b1, 4'd3);
    step(1'b0, 2'b11, 8'h55, 1, 1, 2'b11, 0, '0);
    step(1'b0, 2'b10, 8'hAA, 0, 1, 2'b00, 1'b1, 4'd7);
    step(1'b0, 2'b11, 8'h33, 1, 0, 2'b10, 0, '0);
    idle(2);
    // Arithmetic burst of 2 from 90, then a zero-count burst
    step(1'b0, 2'b11, 8'h90, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b01, 8'h00, 0, 0, 2'b10, 1'b1, 4'd2);
    idle(3);
    step(1'b0, 2'b01, 8'h00, 0, 0, 2'b10, 1'b1, 4'd0);
    step(1'b0, 2'b10, 8'h00, 0, 0, 2'b00, 1'b1, 4'd0);
    idle(2);
    // Left burst of 5 aborted by reset in its second busy cycle; START while busy ignored
    step(1'b0, 2'b11, 8'h3C, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b10, 8'h00, 0, 1, 2'b00, 1'b1, 4'd5);
    step(1'b0, 2'b01, 8'h00, 0, 1, 2'b00, 1'b1, 4'd0);
    step(1'b1, 2'b00, 8'h00, 0, 0, 2'b00, 0, '0);
    idle(2);
    // Long rotate burst wrapping past WIDTH
    step(1'b0, 2'b11, 8'hC1, 0, 0, 2'b00, 0, '0);
    step(1'b0, 2'b10, 8'h00, 0, 0, 2'b01, 1'b1, 4'd15);
    idle(17);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 60) == 0), 2'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom));
    end
    idle(1);
    @(negedge cp);
    #1;
    if (exp_q.size() != 0) begin
      bad++; total++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
